// File: rtl/instr_mem_pkg.sv
// Shared constants and loader state encoding for the instruction memory
// and its run-time loader.
package instr_mem_pkg;

  localparam int INSTR_W     = 32;
  localparam int IMEM_DEPTH  = 1024;
  localparam int IMEM_ADDR_W = 32;
  localparam int WORD_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loaderState_e;

endpackage

// File: rtl/byte_to_word_packer.sv
// Collects bytes MSB-first into a big-endian instruction word and flags
// the byte that completes it.
module byte_to_word_packer
  import instr_mem_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               byteValid_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               wordValid_o
);

  localparam int CNT_BITS = $clog2(WORD_BYTES);

  logic [CNT_BITS-1:0] byteCnt_q, byteCnt_d;
  logic [INSTR_W-1:0]  shreg_q, shreg_d;
  logic                lastByte;

  assign lastByte    = (byteCnt_q == CNT_BITS'(WORD_BYTES - 1));
  assign wordValid_o = byteValid_i && lastByte;
  assign word_o      = shreg_q;

  // Clear wins over an incoming byte so an abandoned word never completes.
  always_comb begin
    byteCnt_d = byteCnt_q;
    shreg_d   = shreg_q;
    if (clear_i) begin
      byteCnt_d = '0;
      shreg_d   = '0;
    end else if (byteValid_i) begin
      shreg_d   = {shreg_q[INSTR_W-9:0], byte_i};
      byteCnt_d = lastByte ? '0 : byteCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      byteCnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      byteCnt_q <= byteCnt_d;
      shreg_q   <= shreg_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream instruction memory writer: packs bytes into words, writes
// them at consecutive word addresses and holds the CPU while loading.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int                     DEPTH     = IMEM_DEPTH,
  parameter logic [IMEM_ADDR_W-1:0] BASE_ADDR = 32'd0,
  parameter int                     CNT_W     = 11
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       num_words,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   mem_we,
  output logic [IMEM_ADDR_W-1:0] mem_addr,
  output logic [INSTR_W-1:0]     mem_wdata,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [CNT_W-1:0]       words_written
);

  localparam logic [CNT_W-1:0] DEPTH_W = CNT_W'(DEPTH);

  loaderState_e           state_q, state_d;
  logic [CNT_W-1:0]       numWords_q;
  logic [CNT_W-1:0]       wordsWritten_q;
  logic [IMEM_ADDR_W-1:0] memAddr_q;
  logic                   error_q;

  logic startAccept, byteAccept, wordValid, packerClear, lastWord;

  assign startAccept = start && !abort && (state_q == IDLE || state_q == DONE);
  assign byteAccept  = byte_valid && byte_ready && !abort;
  assign packerClear = abort || startAccept;
  assign lastWord    = (wordsWritten_q + CNT_W'(1)) == numWords_q;

  byte_to_word_packer uPacker (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .clear_i     (packerClear),
    .byteValid_i (byteAccept),
    .byte_i      (byte_data),
    .word_o      (mem_wdata),
    .wordValid_o (wordValid)
  );

  // Abort overrides every transition, including a simultaneous start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (num_words > DEPTH_W || num_words == '0) state_d = DONE;
          else                                        state_d = LOAD;
        end
      end
      LOAD:    if (wordValid) state_d = WRITE;
      WRITE:   state_d = lastWord ? DONE : LOAD;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      numWords_q     <= '0;
      wordsWritten_q <= '0;
      memAddr_q      <= '0;
      error_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (startAccept) begin
        numWords_q     <= num_words;
        wordsWritten_q <= '0;
        memAddr_q      <= BASE_ADDR;
        error_q        <= (num_words > DEPTH_W);
      end else if (!abort && state_q == WRITE) begin
        wordsWritten_q <= wordsWritten_q + CNT_W'(1);
        memAddr_q      <= memAddr_q + IMEM_ADDR_W'(WORD_BYTES);
      end
    end
  end

  assign byte_ready    = (state_q == LOAD);
  assign mem_we        = (state_q == WRITE);
  assign mem_addr      = memAddr_q;
  assign busy          = (state_q == LOAD) || (state_q == WRITE);
  assign cpu_hold      = busy;
  assign done          = (state_q == DONE) && !error_q;
  assign error         = (state_q == DONE) && error_q;
  assign words_written = wordsWritten_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised scoreboard bench for instr_mem_loader: a reference model derives
// every expected memory write from the byte stream and word count.
module tb_instr_mem_loader;

  localparam int          CNT_W = 11;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'd0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } memWrite_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] num_words = '0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = '0;
  logic             byte_ready, mem_we, cpu_hold, busy, done, error;
  logic [31:0]      mem_addr, mem_wdata;
  logic [CNT_W-1:0] words_written;

  int        checks = 0;
  int        errors = 0;
  memWrite_t expQ[$];
  logic [7:0] stream[$];

  instr_mem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .num_words     (num_words),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
      end else begin
        memWrite_t e;
        e = expQ.pop_front();
        checkOutput("write_addr", mem_addr, e.addr);
        checkOutput("write_data", mem_wdata, e.data);
        checkOutput("ready_in_write", {31'd0, byte_ready}, 32'd0);
      end
    end
  end

  // Reference model: word i is bytes 4i..4i+3 MSB first at BASE + 4i.
  task automatic pushExpected(input int first, input int nWords);
    for (int i = 0; i < nWords; i++) begin
      memWrite_t e;
      int b;
      b = first + 4 * i;
      e.addr = BASE + 32'(4 * i);
      e.data = {stream[b], stream[b+1], stream[b+2], stream[b+3]};
      expQ.push_back(e);
    end
  endtask

  task automatic fillRandom(input int nBytes);
    stream.delete();
    for (int i = 0; i < nBytes; i++) stream.push_back(8'($urandom));
  endtask

  task automatic applyStimulus(input logic [CNT_W-1:0] n);
    start     = 1'b1;
    num_words = n;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // gapMode: 0 back-to-back, 1 valid low one cycle per byte, 2 random gaps
  task automatic sendBytes(input int first, input int count, input int gapMode);
    for (int i = first; i < first + count; i++) begin
      int gap;
      bit taken;
      gap = (gapMode == 0) ? 0 : (gapMode == 1) ? 1 : int'($urandom_range(0, 2));
      byte_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      byte_valid = 1'b1;
      byte_data  = stream[i];
      taken      = 1'b0;
      for (int c = 0; c < 50 && !taken; c++) begin
        @(negedge clk);
        if (byte_ready) begin
          @(posedge clk); #1;
          taken = 1'b1;
        end
      end
      if (!taken) begin
        byte_valid = 1'b0;
        checkOutput("byte_accept_timeout", 32'd0, 32'd1);
        return;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic waitEnd();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (done || error) seen = 1'b1;
    end
    if (!seen) checkOutput("session_end_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_we"},    {31'd0, mem_we}, 32'd0);
    checkOutput({tag, "_addr"},  mem_addr, 32'd0);
    checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_flags"}, {26'd0, byte_ready, cpu_hold, busy, done, error, 1'b0}, 32'd0);
    checkOutput({tag, "_count"}, 32'(words_written), 32'd0);
  endtask

  task automatic checkFinished(input string tag, input int n);
    checkOutput({tag, "_done"},  {31'd0, done}, 32'd1);
    checkOutput({tag, "_error"}, {31'd0, error}, 32'd0);
    checkOutput({tag, "_count"}, 32'(words_written), 32'(n));
    checkOutput({tag, "_hold"},  {30'd0, cpu_hold, busy}, 32'd0);
    checkOutput({tag, "_queue"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int n, gm;
    $display("[TB] instr_mem_loader bench starting");
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkIdleZero("reset");

    // Directed two-word stream, back-to-back then with gaps.
    for (int pass = 0; pass < 2; pass++) begin
      stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'hA1, 8'h00, 8'h04};
      @(posedge clk); #1;
      pushExpected(0, 2);
      applyStimulus(CNT_W'(2));
      sendBytes(0, 8, pass);
      waitEnd();
      checkFinished(pass == 0 ? "b2b" : "toggle", 2);
    end

    // Randomised sessions against the model.
    for (int s = 0; s < 6; s++) begin
      n  = int'($urandom_range(1, 5));
      gm = int'($urandom_range(0, 2));
      fillRandom(4 * n);
      pushExpected(0, n);
      applyStimulus(CNT_W'(n));
      sendBytes(0, 4 * n, gm);
      waitEnd();
      checkFinished("random", n);
    end

    // Zero words: straight to DONE, no writes.
    applyStimulus(CNT_W'(0));
    @(negedge clk);
    checkFinished("zero", 0);

    // Over DEPTH: rejected with error.
    applyStimulus(CNT_W'(DEPTH + 1));
    @(negedge clk);
    checkOutput("over_error", {31'd0, error}, 32'd1);
    checkOutput("over_done",  {31'd0, done}, 32'd0);
    checkOutput("over_busy",  {31'd0, busy}, 32'd0);

    // Exactly DEPTH is accepted; abort it right away.
    applyStimulus(CNT_W'(DEPTH));
    @(negedge clk);
    checkOutput("depth_busy",  {31'd0, busy}, 32'd1);
    checkOutput("depth_error", {31'd0, error}, 32'd0);
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;

    // Abort after six bytes of a three-word session, then restart.
    fillRandom(12);
    pushExpected(0, 1);
    applyStimulus(CNT_W'(3));
    sendBytes(0, 6, 0);
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_flags", {29'd0, busy, done, error}, 32'd0);
    checkOutput("abort_queue", 32'(expQ.size()), 32'd0);
    stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    pushExpected(0, 1);
    applyStimulus(CNT_W'(1));
    sendBytes(0, 4, 0);
    waitEnd();
    checkFinished("restart", 1);

    // Reset mid-word: partial word must never be written.
    fillRandom(8);
    applyStimulus(CNT_W'(2));
    sendBytes(0, 2, 0);
    reset_n = 1'b0; @(posedge clk); #1; reset_n = 1'b1;
    @(negedge clk);
    checkIdleZero("midreset");
    repeat (4) @(negedge clk);
    fillRandom(4);
    pushExpected(0, 1);
    applyStimulus(CNT_W'(1));
    sendBytes(0, 4, 2);
    waitEnd();
    checkFinished("post_reset", 1);

    // Start while busy is ignored; original count governs.
    fillRandom(8);
    pushExpected(0, 2);
    applyStimulus(CNT_W'(2));
    sendBytes(0, 3, 0);
    applyStimulus(CNT_W'(5));
    sendBytes(3, 5, 0);
    waitEnd();
    checkFinished("start_busy", 2);
    repeat (3) @(negedge clk);
    checkOutput("final_queue", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
